// File: rtl/asteroid_pkg.sv
// Shared types and constants for the asteroid spawn blocks and other
// randomised game logic.
package asteroid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BURST_WAIT,
        OFFER,
        HOLD,
        ROLL
    } state_e;

    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DFLT = 16'hACE1;

    localparam logic [7:0]  RAMP_STEP  = 8'd16;
    localparam int          RAMP_EVERY = 4;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/asteroid_spawner_if.sv
// Spawn offer channel between the spawner (master) and the asteroid allocator (slave).
interface asteroid_spawner_if #(
    parameter int LANE_W = 2
);
    logic              spawn_valid;
    logic [LANE_W-1:0] spawn_lane;
    logic              spawn_ready;

    modport master (
        output spawn_valid,
        output spawn_lane,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid,
        input  spawn_lane,
        output spawn_ready
    );
endinterface

// File: rtl/asteroid_lfsr.sv
// Free-running 16-bit Galois LFSR; loads its seed on reset and shifts every cycle.
// A zero seed would lock up, so it is swapped for the package default.
module asteroid_lfsr
    import asteroid_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_SEED_DFLT : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/asteroid_spawner.sv
// Asteroid spawn scheduler: an initial burst of spawns, then periodic LFSR rolls.
// Defining ASTEROID_SPAWN_RAMP_EN adds a difficulty ramp on the roll threshold.
module asteroid_spawner
    import asteroid_pkg::*;
#(
    parameter int          N_LANES     = 4,
    parameter int          BURST_COUNT = 5,
    parameter int          BURST_GAP   = 12500000,
    parameter int          HOLD_DELAY  = 50000000,
    parameter int          CNT_W       = 32,
    parameter int          MAX_LIVE    = 8,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [7:0]         prob_thresh,
    input  logic [7:0]         live_count,
    output logic               burst_done,
    asteroid_spawner_if.master spawn
);

    localparam int               LANE_W       = $clog2(N_LANES);
    localparam logic [CNT_W-1:0] BURST_RELOAD = CNT_W'(BURST_GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_RELOAD  = CNT_W'(HOLD_DELAY - 1);
    localparam logic [7:0]       BURST_CNT_L  = 8'(BURST_COUNT);
    localparam logic [7:0]       MAX_LIVE_L   = 8'(MAX_LIVE);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [7:0]         burst_cnt_q, burst_cnt_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic               valid_q, valid_d;
    logic               burst_done_q, burst_done_d;

    logic [15:0]        lfsr;
    logic [7:0]         eff_thresh;
    logic               accept;
    logic               roll_fire;
    logic               unused_lfsr_bits;

    asteroid_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    // Only the lane slice and the roll byte are consumed here.
    assign unused_lfsr_bits = ^lfsr;

`ifdef ASTEROID_SPAWN_RAMP_EN
    logic [7:0] ramp_q, ramp_d;
    logic [1:0] ramp_cnt_q, ramp_cnt_d;
    logic       steady_accept;

    // Burst spawns never count towards the ramp; only post-burst acceptances do.
    assign steady_accept = accept && (burst_cnt_q == BURST_CNT_L);

    always_comb begin
        ramp_d     = ramp_q;
        ramp_cnt_d = ramp_cnt_q;
        if (steady_accept) begin
            if (ramp_cnt_q == 2'(RAMP_EVERY - 1)) begin
                ramp_cnt_d = 2'd0;
                ramp_d     = sat_add8(ramp_q, RAMP_STEP);
            end else begin
                ramp_cnt_d = ramp_cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ramp_q     <= 8'd0;
            ramp_cnt_q <= 2'd0;
        end else begin
            ramp_q     <= ramp_d;
            ramp_cnt_q <= ramp_cnt_d;
        end
    end

    assign eff_thresh = sat_add8(prob_thresh, ramp_q);
`else
    assign eff_thresh = prob_thresh;
`endif

    assign accept    = valid_q && spawn.spawn_ready;
    assign roll_fire = (lfsr[7:0] < eff_thresh) && (live_count < MAX_LIVE_L);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        burst_cnt_d = burst_cnt_q;
        lane_d      = lane_q;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    if (burst_cnt_q == BURST_CNT_L) begin
                        state_d = HOLD;
                        timer_d = HOLD_RELOAD;
                    end else begin
                        state_d = BURST_WAIT;
                        timer_d = BURST_RELOAD;
                    end
                end
            end

            BURST_WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    state_d = OFFER;
                    lane_d  = lfsr[15 -: LANE_W];
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end

            // Once offered, a spawn is held until accepted even if enable drops.
            OFFER: begin
                if (accept) begin
                    if (burst_cnt_q < BURST_CNT_L) begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                    if (!enable) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else if (burst_cnt_d == BURST_CNT_L) begin
                        state_d = HOLD;
                        timer_d = HOLD_RELOAD;
                    end else begin
                        state_d = BURST_WAIT;
                        timer_d = BURST_RELOAD;
                    end
                end
            end

            HOLD: begin
                if (!enable) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    state_d = ROLL;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end

            ROLL: begin
                if (!enable) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (roll_fire) begin
                    state_d = OFFER;
                    lane_d  = lfsr[15 -: LANE_W];
                end else begin
                    state_d = HOLD;
                    timer_d = HOLD_RELOAD;
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        valid_d      = (state_d == OFFER);
        burst_done_d = (burst_cnt_d == BURST_CNT_L);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            burst_cnt_q  <= 8'd0;
            lane_q       <= '0;
            valid_q      <= 1'b0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            burst_cnt_q  <= burst_cnt_d;
            lane_q       <= lane_d;
            valid_q      <= valid_d;
            burst_done_q <= burst_done_d;
        end
    end

    assign spawn.spawn_valid = valid_q;
    assign spawn.spawn_lane  = lane_q;
    assign burst_done        = burst_done_q;

endmodule

// File: tb/tb_asteroid_spawner.sv
// Randomised bench for asteroid_spawner against an edge-scheduled reference model.
module tb_asteroid_spawner;

    localparam int          N_LANES     = 4;
    localparam int          BURST_COUNT = 3;
    localparam int          BURST_GAP   = 4;
    localparam int          HOLD_DELAY  = 10;
    localparam int          CNT_W       = 32;
    localparam int          MAX_LIVE    = 2;
    localparam logic [15:0] SEED        = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] prob_thresh = 8'd0;
    logic [7:0] live_count = 8'd0;
    logic       burst_done;

    asteroid_spawner_if #(.LANE_W(2)) sif ();

    asteroid_spawner #(
        .N_LANES     (N_LANES),
        .BURST_COUNT (BURST_COUNT),
        .BURST_GAP   (BURST_GAP),
        .HOLD_DELAY  (HOLD_DELAY),
        .CNT_W       (CNT_W),
        .MAX_LIVE    (MAX_LIVE),
        .SEED        (SEED)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .prob_thresh (prob_thresh),
        .live_count  (live_count),
        .burst_done  (burst_done),
        .spawn       (sif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model: spawns are scheduled as absolute edge numbers.
    // A burst offer appears BURST_GAP edges after its trigger, a roll is
    // decided HOLD_DELAY+1 edges after its trigger using the LFSR value
    // present just before that edge.
    logic [15:0] m_lfsr;
    int          m_edge;
    int          m_deadline;
    int          m_burst;
    int          m_rolls;
    int          m_accepts;
    bit          m_active;
    bit          m_offer;
    bit          m_is_roll;
    logic [1:0]  m_lane;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_reset();
        m_lfsr   = SEED;
        m_edge   = 0;
        m_burst  = 0;
        m_active = 0;
        m_offer  = 0;
    endtask

    task automatic schedule_next();
        m_is_roll  = (m_burst == BURST_COUNT);
        m_deadline = m_edge + (m_is_roll ? HOLD_DELAY + 1 : BURST_GAP);
    endtask

    task automatic model_edge();
        logic [15:0] cur;
        cur = m_lfsr;
        m_edge++;
        if (m_offer) begin
            if (sif.spawn_ready) begin
                m_offer = 0;
                m_accepts++;
                if (m_burst < BURST_COUNT) m_burst++;
                $display("spawn %0d: lane %0d accepted at cycle %0d (burst %0d/%0d)",
                         m_accepts, m_lane, cyc, m_burst, BURST_COUNT);
                if (!enable) m_active = 0;
                else schedule_next();
            end
        end else if (m_active) begin
            if (!enable) begin
                m_active = 0;
            end else if (m_edge == m_deadline) begin
                if (!m_is_roll) begin
                    m_offer = 1;
                    m_lane  = cur[15:14];
                end else begin
                    m_rolls++;
                    if (cur[7:0] < prob_thresh && int'(live_count) < MAX_LIVE) begin
                        m_offer = 1;
                        m_lane  = cur[15:14];
                    end else begin
                        m_deadline = m_edge + HOLD_DELAY + 1;
                    end
                end
            end
        end else if (enable) begin
            m_active = 1;
            schedule_next();
        end
        m_lfsr = lfsr_next(cur);
    endtask

    // Observation of DUT valid rising edges.
    bit         prev_valid = 0;
    int         rises      = 0;
    int         high_cnt   = 0;
    int         rise_cyc[$];
    logic [3:0] lanes_seen = 4'h0;

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check("valid", 32'(sif.spawn_valid), 32'(m_offer));
        if (m_offer) check("lane", 32'(sif.spawn_lane), 32'(m_lane));
        check("burst_done", 32'(burst_done), 32'(m_burst == BURST_COUNT));
        if (sif.spawn_valid === 1'b1) begin
            high_cnt++;
            if (!prev_valid) begin
                rises++;
                rise_cyc.push_back(cyc);
                lanes_seen[sif.spawn_lane] = 1'b1;
            end
        end
        prev_valid = (sif.spawn_valid === 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b0;
        enable = 1'b0;
        #1;
        check("rst_async_valid", 32'(sif.spawn_valid), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(sif.spawn_valid), 32'd0);
        check("rst_lane", 32'(sif.spawn_lane), 32'd0);
        check("rst_burst_done", 32'(burst_done), 32'd0);
        model_reset();
        prev_valid = 0;
        rst = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int n;
        n = 0;
        while (sif.spawn_valid !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check(tag, 32'(sif.spawn_valid), 32'd1);
    endtask

    task automatic run_rolls(input string tag, input int target);
        int guard;
        guard   = 0;
        m_rolls = 0;
        while (m_rolls < target && guard < 20000) begin
            tick();
            guard++;
        end
        check(tag, 32'(m_rolls >= target), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        sif.spawn_ready = 1'b0;

        // Burst with ready held high.
        do_reset();
        enable = 1'b1;
        sif.spawn_ready = 1'b1;
        rises = 0; high_cnt = 0; rise_cyc.delete();
        repeat (40) tick();
        check("burst_pulses", 32'(rises), 32'd3);
        check("burst_single_cycle", 32'(high_cnt), 32'd3);
        if (rise_cyc.size() == 3) begin
            check("burst_gap1", 32'(rise_cyc[1] - rise_cyc[0]), 32'(BURST_GAP + 1));
            check("burst_gap2", 32'(rise_cyc[2] - rise_cyc[1]), 32'(BURST_GAP + 1));
        end
        check("burst_done_after", 32'(burst_done), 32'd1);

        // Backpressure on the second burst offer.
        do_reset();
        enable = 1'b1;
        sif.spawn_ready = 1'b1;
        begin
            int n;
            logic [1:0] lane0;
            n = 0;
            while (m_burst < 1 && n < 30) begin tick(); n++; end
            check("bp_first_accept", 32'(m_burst), 32'd1);
            sif.spawn_ready = 1'b0;
            wait_valid("bp_second_offer", 30);
            lane0 = sif.spawn_lane;
            high_cnt = 1;
            repeat (7) begin
                tick();
                check("bp_lane_stable", 32'(sif.spawn_lane), 32'(lane0));
            end
            check("bp_valid_held", 32'(high_cnt), 32'd8);
            sif.spawn_ready = 1'b1;
            tick();
            check("bp_not_done_yet", 32'(burst_done), 32'd0);
            rises = 0;
            n = 0;
            while (burst_done !== 1'b1 && n < 30) begin tick(); n++; end
            check("bp_one_more_offer", 32'(rises), 32'd1);
        end

        // Steady-state gating by the live-asteroid cap.
        prob_thresh = 8'd255;
        live_count  = 8'd2;
        rises = 0;
        repeat (100) tick();
        check("cap_blocks", 32'(rises), 32'd0);
        live_count = 8'd0;
        wait_valid("cap_released", 2 * (HOLD_DELAY + 1) + 2);

        // Probability sweep.
        sif.spawn_ready = 1'b1;
        prob_thresh = 8'd0;
        repeat (2) tick();
        rises = 0;
        run_rolls("p0_rolls", 1000);
        check("p0_no_spawn", 32'(rises), 32'd0);
        prob_thresh = 8'd128;
        rises = 0;
        lanes_seen = 4'h0;
        run_rolls("p128_rolls", 1000);
        check("p128_rate", 32'(rises >= 400 && rises <= 600), 32'd1);
        check("p128_lanes", 32'(lanes_seen), 32'hF);

        // Disable while an offer is stalled.
        prob_thresh = 8'd255;
        sif.spawn_ready = 1'b0;
        wait_valid("dis_offer", 3 * (HOLD_DELAY + 1));
        enable = 1'b0;
        repeat (3) tick();
        check("dis_valid_kept", 32'(sif.spawn_valid), 32'd1);
        sif.spawn_ready = 1'b1;
        tick();
        rises = 0;
        repeat (20) tick();
        check("dis_idle", 32'(rises), 32'd0);
        enable = 1'b1;
        wait_valid("reenable_offer", 3 * (HOLD_DELAY + 1));

        // Randomised traffic on every input.
        repeat (3000) begin
            sif.spawn_ready = 1'($urandom_range(0, 1));
            prob_thresh     = 8'($urandom);
            live_count      = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            tick();
        end

        // Reset asserted while a spawn is on offer.
        enable = 1'b1;
        prob_thresh = 8'd255;
        live_count = 8'd0;
        sif.spawn_ready = 1'b0;
        wait_valid("rst_mid_offer_setup", 4 * (HOLD_DELAY + 1));
        do_reset();
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
